// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch front end and the decoder:
// data/address widths, fetch FSM state encodings, operand-length codes and
// opcode field slices.
package fetch_sequencer_pkg;

    localparam int REG_WIDTH  = 8;
    localparam int ADDR_WIDTH = 16;

    // Fetch FSM states, 3-bit encoding shared with the decoder.
    typedef enum logic [2:0] {
        FS_IDLE    = 3'd0,
        FS_OPC     = 3'd1,
        FS_LO      = 3'd2,
        FS_HI      = 3'd3,
        FS_CAP     = 3'd4,
        FS_PRESENT = 3'd5,
        FS_WAIT    = 3'd6
    } fs_state_e;

    // Instruction length in bytes (opcode plus operand bytes).
    localparam logic [1:0] OPLEN_1 = 2'd1;
    localparam logic [1:0] OPLEN_2 = 2'd2;
    localparam logic [1:0] OPLEN_3 = 2'd3;

    // 6502 opcodes are laid out as aaa_bbb_cc.
    function automatic logic [1:0] op_cc(input logic [REG_WIDTH-1:0] op);
        return op[1:0];
    endfunction

    function automatic logic [2:0] op_bbb(input logic [REG_WIDTH-1:0] op);
        return op[4:2];
    endfunction

    function automatic logic [2:0] op_aaa(input logic [REG_WIDTH-1:0] op);
        return op[7:5];
    endfunction

endpackage

// File: rtl/fetch_sequencer_op_length.sv
// Combinational opcode -> instruction length (1..3 bytes). Kept as its own
// block so a disassembly monitor can reuse it.
module fetch_sequencer_op_length
    import fetch_sequencer_pkg::*;
(
    input  logic [REG_WIDTH-1:0] opcode_i,
    output logic [1:0]           len_o
);

    logic [2:0] bbb;
    logic [2:0] aaa;

    assign bbb = op_bbb(opcode_i);
    assign aaa = op_aaa(opcode_i);

    // Decode the addressing-mode field into a byte count.
    always_comb begin
        // NOTE: assign a default before the case so every path drives len_o and no latch is inferred.
        len_o = OPLEN_1;
        case (op_cc(opcode_i))
            2'b01: begin
                if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) begin
                    len_o = OPLEN_3;
                end else begin
                    len_o = OPLEN_2;
                end
            end
            2'b11: begin
                // Undefined group; the decoder deals with illegal opcodes.
                len_o = OPLEN_1;
            end
            default: begin
                case (bbb)
                    // Immediate only for the upper half (LDY/CPY/CPX/LDX #...).
                    3'b000:          len_o = aaa[2] ? OPLEN_2 : OPLEN_1;
                    // Zero page, zero page indexed, and relative branches.
                    3'b001, 3'b101,
                    3'b100:          len_o = OPLEN_2;
                    3'b011, 3'b111:  len_o = OPLEN_3;
                    // Implied / accumulator forms (010, 110).
                    default:         len_o = OPLEN_1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch front end of the 6502 core. Reads opcode and operand
// bytes at PC, presents the assembled instruction to the decoder, holds it
// until the decoder signals completion, then advances or redirects PC.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 16'h0600
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  halt,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [REG_WIDTH-1:0]  mem_data,
    output logic [REG_WIDTH-1:0]  instruction_in,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic                  instruction_ready,
    input  logic                  instruction_done,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic [ADDR_WIDTH-1:0] pc
);

    fs_state_e             state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [1:0]            len_q;
    logic                  mem_rd_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [REG_WIDTH-1:0]  instr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  ready_q;

    // Length of the opcode currently on the memory bus (valid in FS_LO).
    logic [1:0]            len_d;

    fetch_sequencer_op_length u_op_length (
        .opcode_i (mem_data),
        .len_o    (len_d)
    );

    // Fetch FSM with registered memory strobe and decoder-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FS_IDLE;
            pc_q       <= RESET_PC;
            len_q      <= OPLEN_1;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            instr_q    <= '0;
            addr_q     <= '0;
            ready_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees the pre-edge values.
            // The read strobe is a single-cycle pulse unless a state re-arms it.
            mem_rd_q <= 1'b0;
            case (state_q)
                FS_IDLE: begin
                    if (!halt) begin
                        state_q <= FS_OPC;
                    end
                end
                FS_OPC: begin
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= pc_q;
                    state_q    <= FS_LO;
                end
                FS_LO: begin
                    instr_q <= mem_data;
                    addr_q  <= '0;
                    len_q   <= len_d;
                    if (len_d == OPLEN_1) begin
                        state_q <= FS_PRESENT;
                    end else begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= pc_q + ADDR_WIDTH'(1);
                        state_q    <= FS_HI;
                    end
                end
                FS_HI: begin
                    addr_q[REG_WIDTH-1:0] <= mem_data;
                    if (len_q == OPLEN_2) begin
                        state_q <= FS_PRESENT;
                    end else begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= pc_q + ADDR_WIDTH'(2);
                        state_q    <= FS_CAP;
                    end
                end
                FS_CAP: begin
                    addr_q[ADDR_WIDTH-1:REG_WIDTH] <= mem_data;
                    state_q <= FS_PRESENT;
                end
                FS_PRESENT: begin
                    ready_q <= 1'b1;
                    state_q <= FS_WAIT;
                end
                FS_WAIT: begin
                    if (instruction_done) begin
                        ready_q <= 1'b0;
                        // A redirect takes priority over sequential advance.
                        pc_q    <= pc_load ? pc_load_value : pc_q + ADDR_WIDTH'(len_q);
                        state_q <= FS_IDLE;
                    end
                end
                default: begin
                    state_q <= FS_IDLE;
                end
            endcase
        end
    end

    assign mem_rd            = mem_rd_q;
    assign mem_addr          = mem_addr_q;
    assign instruction_in    = instr_q;
    assign addr_in           = addr_q;
    assign instruction_ready = ready_q;
    assign pc                = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a flat byte memory answers reads
// combinationally from mem_addr, and a scripted decoder pulses
// instruction_done once each instruction is presented.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset_n;
    logic        halt;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  instruction_in;
    logic [15:0] addr_in;
    logic        instruction_ready;
    logic        instruction_done;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic [15:0] pc;

    logic [7:0]  mem [0:65535];

    int n_checks;
    int n_errors;

    fetch_sequencer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .halt              (halt),
        .mem_rd            (mem_rd),
        .mem_addr          (mem_addr),
        .mem_data          (mem_data),
        .instruction_in    (instruction_in),
        .addr_in           (addr_in),
        .instruction_ready (instruction_ready),
        .instruction_done  (instruction_done),
        .pc_load           (pc_load),
        .pc_load_value     (pc_load_value),
        .pc                (pc)
    );

    assign mem_data = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Release halt for one edge, follow the fetch to instruction_ready, check
    // latency, read addresses and presented fields, then retire it with done.
    task automatic run_fetch(input string tag, input logic [15:0] start, input int exp_len,
                             input logic [7:0] exp_op, input logic [15:0] exp_operand,
                             input logic do_load, input logic [15:0] load_val,
                             input logic [15:0] exp_next_pc);
        int          n;
        int          nrd;
        bit          seen;
        logic [15:0] rd_addr [0:3];
        logic [15:0] ea;
        n    = 0;
        nrd  = 0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) rd_addr[i] = 16'h0;
        @(negedge clk);
        halt = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            // Re-assert halt mid-fetch; it must not disturb this instruction.
            if (n == 1) halt = 1'b1;
            if (mem_rd) begin
                if (nrd < 4) rd_addr[nrd] = mem_addr;
                nrd++;
            end
            if (instruction_ready) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(n - 1), 32'(exp_len + 2));
        check({tag, "_num_reads"}, 32'(nrd), 32'(exp_len));
        for (int i = 0; i < exp_len; i++) begin
            ea = start + 16'(i);
            check($sformatf("%s_rd_addr%0d", tag, i), {16'h0, rd_addr[i]}, {16'h0, ea});
        end
        check({tag, "_opcode"}, {24'h0, instruction_in}, {24'h0, exp_op});
        check({tag, "_operand"}, {16'h0, addr_in}, {16'h0, exp_operand});
        check({tag, "_pc_hold"}, {16'h0, pc}, {16'h0, start});
        // Ready and outputs stay put while the decoder works.
        repeat (2) @(negedge clk);
        check({tag, "_ready_held"}, {31'h0, instruction_ready}, 32'h1);
        check({tag, "_no_rd_wait"}, {31'h0, mem_rd}, 32'h0);
        instruction_done = 1'b1;
        pc_load          = do_load;
        pc_load_value    = load_val;
        @(negedge clk);
        instruction_done = 1'b0;
        pc_load          = 1'b0;
        check({tag, "_ready_drop"}, {31'h0, instruction_ready}, 32'h0);
        check({tag, "_next_pc"}, {16'h0, pc}, {16'h0, exp_next_pc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        reset_n          = 1'b0;
        halt             = 1'b1;
        instruction_done = 1'b0;
        pc_load          = 1'b0;
        pc_load_value    = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'h0600] = 8'hA9; mem[16'h0601] = 8'h42;                        // LDA #$42
        mem[16'h0602] = 8'hAD; mem[16'h0603] = 8'h34; mem[16'h0604] = 8'h12; // LDA $1234
        mem[16'h0605] = 8'hEA;                                               // NOP
        mem[16'hFFFF] = 8'h8D; mem[16'h0000] = 8'hCD; mem[16'h0001] = 8'hAB; // STA $ABCD
        mem[16'h0002] = 8'hA2; mem[16'h0003] = 8'h7F;                        // LDX #$7F
        mem[16'h0004] = 8'h20;                                               // aaa=001 bbb=000: 1 byte
        mem[16'h0005] = 8'hAD; mem[16'h0006] = 8'h11; mem[16'h0007] = 8'h22;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_pc", {16'h0, pc}, 32'h0600);
        check("rst_ready", {31'h0, instruction_ready}, 32'h0);
        check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        check("rst_instr", {24'h0, instruction_in}, 32'h0);
        check("rst_addr_in", {16'h0, addr_in}, 32'h0);
        reset_n = 1'b1;

        // Halted in IDLE: no reads; a stray done with redirect is ignored.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("halt_no_rd%0d", c), {31'h0, mem_rd}, 32'h0);
            instruction_done = (c == 3);
            pc_load          = (c == 3);
            pc_load_value    = 16'h1234;
        end
        instruction_done = 1'b0;
        pc_load          = 1'b0;
        @(negedge clk);
        check("stray_done_pc", {16'h0, pc}, 32'h0600);
        check("stray_done_ready", {31'h0, instruction_ready}, 32'h0);

        run_fetch("lda_imm", 16'h0600, 2, 8'hA9, 16'h0042, 1'b0, 16'h0, 16'h0602);
        run_fetch("lda_abs", 16'h0602, 3, 8'hAD, 16'h1234, 1'b0, 16'h0, 16'h0605);
        run_fetch("nop_jmp", 16'h0605, 1, 8'hEA, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF);
        run_fetch("wrap_sta", 16'hFFFF, 3, 8'h8D, 16'hABCD, 1'b0, 16'h0, 16'h0002);
        run_fetch("ldx_imm", 16'h0002, 2, 8'hA2, 16'h007F, 1'b0, 16'h0, 16'h0004);
        run_fetch("imm_lo", 16'h0004, 1, 8'h20, 16'h0000, 1'b0, 16'h0, 16'h0005);

        // Asynchronous reset while in HI of a 3-byte fetch at 0005.
        @(negedge clk);
        halt = 1'b0;
        @(posedge clk);          // leave IDLE -> OPC
        @(negedge clk);
        halt = 1'b1;
        @(posedge clk);          // -> LO, read 0005
        @(posedge clk);          // -> HI, read 0006
        #1;
        check("pre_rst_rd", {31'h0, mem_rd}, 32'h1);
        check("pre_rst_addr", {16'h0, mem_addr}, 32'h0006);
        #2;
        reset_n = 1'b0;
        #1;
        check("midhi_rst_pc", {16'h0, pc}, 32'h0600);
        check("midhi_rst_rd", {31'h0, mem_rd}, 32'h0);
        check("midhi_rst_addr", {16'h0, mem_addr}, 32'h0);
        check("midhi_rst_instr", {24'h0, instruction_in}, 32'h0);
        check("midhi_rst_addr_in", {16'h0, addr_in}, 32'h0);
        check("midhi_rst_ready", {31'h0, instruction_ready}, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_ready", {31'h0, instruction_ready}, 32'h0);
        check("post_rst_pc", {16'h0, pc}, 32'h0600);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
